// File: rtl/game_pkg.sv
// Shared encodings for the game counter: step modes, FSM states, result codes.
// mode_step() maps a mode to its signed step so the counter needs one adder.
package game_pkg;

    typedef enum logic [1:0] {
        MODE_UP1 = 2'b00,
        MODE_UP2 = 2'b01,
        MODE_DN1 = 2'b10,
        MODE_DN2 = 2'b11
    } mode_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_WIN  = 2'b01;
    localparam logic [1:0] WHO_LOSE = 2'b10;

    function automatic int mode_step(input mode_e m);
        case (m)
            MODE_UP1: return 1;
            MODE_UP2: return 2;
            MODE_DN1: return -1;
            default:  return -2;
        endcase
    endfunction

endpackage

// File: rtl/game_hold_timer.sv
// Counts the game-over hold period; done is high during the last hold cycle.
// start is sampled on the same edge that moves the FSM into OVER.
module game_hold_timer #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] hold_cnt_reg;
    logic          active_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt_reg <= '0;
            active_reg   <= 1'b0;
        end else if (start) begin
            hold_cnt_reg <= CW'(HOLD_CYCLES - 1);
            active_reg   <= 1'b1;
        end else if (active_reg) begin
            if (hold_cnt_reg == '0) begin
                active_reg <= 1'b0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg - CW'(1);
            end
        end
    end

    assign done = active_reg && (hold_cnt_reg == '0);

endmodule

// File: rtl/game_counter.sv
// Modular up/down game counter with winner/loser pulses and a timed game-over
// state that restarts the game and clears the downstream event counters.
module game_counter
    import game_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    input  logic             winner_flag,
    input  logic             loser_flag,
    output logic [WIDTH-1:0] count,
    output logic             winner,
    output logic             loser,
    output logic             game_over,
    output logic [1:0]       who,
    output logic             clr_counters
);

    state_e           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] step_next;
    logic             winner_reg;
    logic             loser_reg;
    logic [1:0]       who_reg;
    logic             clr_reg;
    logic             flag_hit;
    logic             hold_done;

    assign step_next = count_reg + WIDTH'(mode_step(mode_e'(mode)));

    // Flags seen in the restart (clear) cycle are stale results of the old game.
    assign flag_hit = (state_reg == ST_RUN) && !clr_reg && (winner_flag || loser_flag);

    game_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .start(flag_hit),
        .done (hold_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_RUN;
            count_reg  <= '0;
            winner_reg <= 1'b0;
            loser_reg  <= 1'b0;
            who_reg    <= WHO_NONE;
            clr_reg    <= 1'b0;
        end else begin
            winner_reg <= 1'b0;
            loser_reg  <= 1'b0;
            clr_reg    <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (flag_hit) begin
                        state_reg <= ST_OVER;
                        who_reg   <= winner_flag ? WHO_WIN : WHO_LOSE;
                    end else if (load) begin
                        count_reg <= init;
                    end else begin
                        count_reg  <= step_next;
                        winner_reg <= (step_next == '1);
                        loser_reg  <= (step_next == '0);
                    end
                end
                default: begin
                    if (hold_done) begin
                        state_reg <= ST_RUN;
                        count_reg <= '0;
                        who_reg   <= WHO_NONE;
                        clr_reg   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign count        = count_reg;
    assign winner       = winner_reg;
    assign loser        = loser_reg;
    assign game_over    = (state_reg == ST_OVER);
    assign who          = who_reg;
    assign clr_counters = clr_reg;

endmodule

// File: tb/tb_game_counter.sv
// Directed scoreboard bench for game_counter: each driven cycle queues its
// hand-computed outputs, and a monitor compares them one cycle later.
module tb_game_counter;

    typedef struct packed {
        logic [3:0] count;
        logic       winner;
        logic       loser;
        logic       game_over;
        logic [1:0] who;
        logic       clr;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] init = 4'd0;
    logic       winner_flag = 1'b0;
    logic       loser_flag = 1'b0;
    logic [3:0] count;
    logic       winner;
    logic       loser;
    logic       game_over;
    logic [1:0] who;
    logic       clr_counters;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    txn = 0;

    game_counter #(
        .WIDTH(4),
        .HOLD_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .load        (load),
        .init        (init),
        .winner_flag (winner_flag),
        .loser_flag  (loser_flag),
        .count       (count),
        .winner      (winner),
        .loser       (loser),
        .game_over   (game_over),
        .who         (who),
        .clr_counters(clr_counters)
    );

    always #5 clk = ~clk;

    // One driven cycle: inputs set at negedge, expected outputs after the next posedge.
    task automatic cyc(input string nm, input logic r, input logic [1:0] m,
                       input logic ld, input logic [3:0] iv, input logic wf,
                       input logic lf, input logic [3:0] ec, input logic ew,
                       input logic el, input logic eg, input logic [1:0] eh,
                       input logic ecl);
        @(negedge clk);
        rst = r; mode = m; load = ld; init = iv;
        winner_flag = wf; loser_flag = lf;
        exp_q.push_back({ec, ew, el, eg, eh, ecl});
        name_q.push_back(nm);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {count, winner, loser, game_over, who, clr_counters};
            checks++;
            txn++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s txn %0d: got count=%0d w=%b l=%b go=%b who=%b clr=%b, want count=%0d w=%b l=%b go=%b who=%b clr=%b",
                         nm, txn, a.count, a.winner, a.loser, a.game_over, a.who, a.clr,
                         e.count, e.winner, e.loser, e.game_over, e.who, e.clr);
            end else begin
                $display("txn %0d %s: count=%0d w=%b l=%b go=%b who=%b clr=%b ok",
                         txn, nm, a.count, a.winner, a.loser, a.game_over, a.who, a.clr);
            end
        end
    end

    initial begin
        // Reset state
        cyc("reset", 0, 2'b00, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 2'b00, 0);
        cyc("reset", 0, 2'b00, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 2'b00, 0);
        // Up-by-1 to all-ones, then wrap to zero
        for (int i = 1; i <= 15; i++)
            cyc("up1", 1, 2'b00, 0, 4'd0, 0, 0, 4'(i), (i == 15), 0, 0, 2'b00, 0);
        cyc("up1_wrap", 1, 2'b00, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, 2'b00, 0);
        // Load 14 then up-by-2 wraps past zero
        cyc("load14", 1, 2'b01, 1, 4'd14, 0, 0, 4'd14, 0, 0, 0, 2'b00, 0);
        cyc("up2_wrap", 1, 2'b01, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, 2'b00, 0);
        cyc("up2", 1, 2'b01, 0, 4'd0, 0, 0, 4'd2, 0, 0, 0, 2'b00, 0);
        // Loads of the terminal values give no pulse
        cyc("load15", 1, 2'b00, 1, 4'd15, 0, 0, 4'd15, 0, 0, 0, 2'b00, 0);
        cyc("load0", 1, 2'b00, 1, 4'd0, 0, 0, 4'd0, 0, 0, 0, 2'b00, 0);
        // Down-by-1 from 1 through zero into all-ones
        cyc("load1", 1, 2'b10, 1, 4'd1, 0, 0, 4'd1, 0, 0, 0, 2'b00, 0);
        cyc("dn1_zero", 1, 2'b10, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, 2'b00, 0);
        cyc("dn1_wrap", 1, 2'b10, 0, 4'd0, 0, 0, 4'd15, 1, 0, 0, 2'b00, 0);
        // Mode changes take effect immediately
        cyc("dn2", 1, 2'b11, 0, 4'd0, 0, 0, 4'd13, 0, 0, 0, 2'b00, 0);
        cyc("up2_win", 1, 2'b01, 0, 4'd0, 0, 0, 4'd15, 1, 0, 0, 2'b00, 0);
        cyc("dn2", 1, 2'b11, 0, 4'd0, 0, 0, 4'd13, 0, 0, 0, 2'b00, 0);
        cyc("load1", 1, 2'b11, 1, 4'd1, 0, 0, 4'd1, 0, 0, 0, 2'b00, 0);
        cyc("dn2_wrap", 1, 2'b11, 0, 4'd0, 0, 0, 4'd15, 1, 0, 0, 2'b00, 0);
        // Both flags: winner priority, count held, 8 game-over cycles
        cyc("over_entry", 1, 2'b00, 0, 4'd0, 1, 1, 4'd15, 0, 0, 1, 2'b01, 0);
        for (int i = 2; i <= 8; i++)
            cyc("over_hold", 1, 2'b00, 1, 4'd5, (i < 4), 0, 4'd15, 0, 0, 1, 2'b01, 0);
        cyc("restart", 1, 2'b00, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 2'b00, 1);
        // Flag sampled in the clear cycle is ignored; the next one is honoured
        cyc("clr_flag_ign", 1, 2'b00, 0, 4'd0, 0, 1, 4'd1, 0, 0, 0, 2'b00, 0);
        cyc("loser_entry", 1, 2'b00, 0, 4'd0, 0, 1, 4'd1, 0, 0, 1, 2'b10, 0);
        for (int i = 2; i <= 4; i++)
            cyc("loser_hold", 1, 2'b00, 0, 4'd0, 0, 0, 4'd1, 0, 0, 1, 2'b10, 0);
        // Reset during hold cycle 4, then no clear pulse afterwards
        cyc("mid_reset", 0, 2'b00, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 2'b00, 0);
        cyc("post_reset", 1, 2'b00, 0, 4'd0, 0, 0, 4'd1, 0, 0, 0, 2'b00, 0);
        cyc("post_reset", 1, 2'b00, 0, 4'd0, 0, 0, 4'd2, 0, 0, 0, 2'b00, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected transactions left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_counter.md
GAME_COUNTER -- requirements
Module: game_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the bit width of the game count.
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 8, giving the number of cycles spent in game-over before automatic restart.
REQ-003 Port clk  input  1  is the single clock; all state changes SHALL occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be a synchronous, active-low reset.
REQ-005 Port mode  input  2  selects the step: 00 up-by-1, 01 up-by-2, 10 down-by-1, 11 down-by-2.
REQ-006 Port load  input  1  requests a load of init into the count.
REQ-007 Port init  input  WIDTH  is the load value.
REQ-008 Port winner_flag  input  1  is the terminal flag from the downstream winner-event counter.
REQ-009 Port loser_flag  input  1  is the terminal flag from the downstream loser-event counter.
REQ-010 Port count  output  WIDTH  is the current game count.
REQ-011 Port winner  output  1  is a one-cycle trigger pulse for the winner-event counter.
REQ-012 Port loser  output  1  is a one-cycle trigger pulse for the loser-event counter.
REQ-013 Port game_over  output  1  is high while the block is in the OVER state.
REQ-014 Port who  output  2  reports the game result: 00 none, 01 winner, 10 loser.
REQ-015 Port clr_counters  output  1  is a one-cycle, active-high clear pulse for both event counters.

Function
REQ-016 The block SHALL implement a two-state FSM with states RUN and OVER; all outputs SHALL be registered.
REQ-017 In RUN with load=1, count SHALL take init on the next edge, and winner and loser SHALL be 0 for that cycle.
REQ-018 In RUN with load=0, count SHALL advance by the mode step, modulo 2^WIDTH, on every edge (wrap-around in both directions).
REQ-019 A mode change SHALL take effect on the first edge at which it is sampled, with no extra latency.
REQ-020 winner SHALL be registered 1 in the same cycle in which a counting step (not a load) sets count to all-ones; otherwise it SHALL be 0.
REQ-021 loser SHALL be registered 1 in the same cycle in which a counting step (not a load) sets count to zero; otherwise it SHALL be 0.
REQ-022 Example: up-by-2 from 14 SHALL produce count=0 with loser=1; up-by-2 from 13 SHALL produce count=15 with winner=1.
REQ-023 In RUN, if winner_flag or loser_flag is sampled 1, the next state SHALL be OVER; on that same edge count SHALL hold and no pulses SHALL be issued.
REQ-024 On entering OVER, who SHALL be 01 if winner_flag=1 (winner has priority when both flags are 1) and 10 otherwise.
REQ-025 In OVER, game_over SHALL be 1, count SHALL be frozen, and winner, loser and load SHALL be ignored or held at 0 as appropriate.
REQ-026 In OVER, a hold counter SHALL count HOLD_CYCLES cycles; on the last cycle the FSM SHALL return to RUN with count=0, who=00 and game_over=0.
REQ-027 clr_counters SHALL be 1 for exactly the first RUN cycle after OVER and 0 at all other times.
REQ-028 Flags sampled during OVER, or during the clr_counters cycle, SHALL NOT re-enter OVER.

Reset
REQ-029 While rst=0 at a clock edge: state SHALL be RUN, count 0, winner 0, loser 0, game_over 0, who 00, clr_counters 0, and hold counter 0.
REQ-030 Reset SHALL override every other input, including in OVER mid-hold; no clr_counters pulse SHALL follow a reset.

Structure
REQ-031 Package game_pkg SHALL hold the mode encoding enum, the state enum (RUN, OVER) and the who encoding constants.
REQ-032 The hold timer SHALL be one sub-module, game_hold_timer (start, done, parameter HOLD_CYCLES); everything else SHALL be in game_counter.

Verification
REQ-033 Scenario: reset, then mode=00 for 15 cycles -> count reaches 15 with winner=1 on that cycle only; the next cycle gives count=0 with loser=1.
REQ-034 Scenario: load init=14, then mode=01 -> count 14, 0 (loser=1), 2; the load cycle has no pulse.
REQ-035 Scenario: mode=10 from 1 -> count 0 with loser=1, then 15 with winner=1 (down wrap).
REQ-036 Scenario: winner_flag=1 and loser_flag=1 together in RUN -> OVER, who=01, game_over=1 for 8 cycles, then count=0 and a single clr_counters pulse.
REQ-037 Scenario: rst=0 asserted on hold cycle 4 of OVER -> all outputs 0, state RUN, and no clr_counters pulse.
